// File: rtl/aha_code_bus_arbiter.sv
// Two-master AHB-Lite arbiter for the CM3 code-region SRAM.
// M0 = merged I-Code/D-Code, M1 = boot/image loader. A master that loses
// arbitration has its address phase captured and replayed later.
module aha_code_bus_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int M1_MAX_CONSEC = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [1:0]            M0_HTRANS,
    input  logic [2:0]            M0_HSIZE,
    input  logic                  M0_HWRITE,
    input  logic [ADDR_WIDTH-1:0] M0_HADDR,
    input  logic [DATA_WIDTH-1:0] M0_HWDATA,
    output logic                  M0_HREADY,
    output logic [1:0]            M0_HRESP,
    output logic [DATA_WIDTH-1:0] M0_HRDATA,
    input  logic [1:0]            M1_HTRANS,
    input  logic [2:0]            M1_HSIZE,
    input  logic                  M1_HWRITE,
    input  logic [ADDR_WIDTH-1:0] M1_HADDR,
    input  logic [DATA_WIDTH-1:0] M1_HWDATA,
    output logic                  M1_HREADY,
    output logic [1:0]            M1_HRESP,
    output logic [DATA_WIDTH-1:0] M1_HRDATA,
    output logic                  S_HSEL,
    output logic [1:0]            S_HTRANS,
    output logic [2:0]            S_HSIZE,
    output logic                  S_HWRITE,
    output logic [ADDR_WIDTH-1:0] S_HADDR,
    output logic [DATA_WIDTH-1:0] S_HWDATA,
    output logic                  S_HREADY,
    input  logic                  S_HREADYOUT,
    input  logic [1:0]            S_HRESP,
    input  logic [DATA_WIDTH-1:0] S_HRDATA
);

    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

    typedef struct packed {
        logic [2:0]            size;
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
    } xfer_t;

    typedef struct packed {
        logic  v;
        xfer_t x;
    } hold_t;

    hold_t      hold0_q, hold0_d, hold1_q, hold1_d;
    xfer_t      last_q, last_d;
    owner_e     owner_q, owner_d;
    logic [3:0] consec_q, consec_d;

    logic  live0, live1, cand0, cand1, grant0, grant1, win_valid;
    xfer_t cand0_x, cand1_x, win_x;

    logic unused_bits;
    assign unused_bits = ^{M0_HTRANS[0], M1_HTRANS[0], S_HRESP[1]};

    // Request detection and grant decision
    always_comb begin
        // The owner's new address phase only counts once its data phase completes
        live0   = !HRESET && M0_HTRANS[1] && !hold0_q.v && (owner_q != OWN_M0 || S_HREADYOUT);
        live1   = !HRESET && M1_HTRANS[1] && !hold1_q.v && (owner_q != OWN_M1 || S_HREADYOUT);
        cand0   = hold0_q.v || live0;
        cand1   = hold1_q.v || live1;
        cand0_x = hold0_q.v ? hold0_q.x : '{size: M0_HSIZE, write: M0_HWRITE, addr: M0_HADDR};
        cand1_x = hold1_q.v ? hold1_q.x : '{size: M1_HSIZE, write: M1_HWRITE, addr: M1_HADDR};
        grant1  = S_HREADYOUT && cand1 && !(cand0 && consec_q == 4'(M1_MAX_CONSEC));
        grant0  = S_HREADYOUT && cand0 && !grant1;
        win_valid = grant0 || grant1;
        win_x     = grant1 ? cand1_x : cand0_x;
    end

    // Next-state: hold capture/clear, starvation counter, data-phase owner
    always_comb begin
        hold0_d = hold0_q;
        if (grant0)     hold0_d.v = 1'b0;
        else if (live0) hold0_d = '{v: 1'b1, x: cand0_x};

        hold1_d = hold1_q;
        if (grant1)     hold1_d.v = 1'b0;
        else if (live1) hold1_d = '{v: 1'b1, x: cand1_x};

        consec_d = consec_q;
        if (!cand0 || grant0) consec_d = '0;
        else if (grant1)      consec_d = consec_q + 4'd1;

        owner_d = owner_q;
        if (S_HREADYOUT) begin
            if (grant0)      owner_d = OWN_M0;
            else if (grant1) owner_d = OWN_M1;
            else             owner_d = OWN_NONE;
        end

        last_d = win_valid ? win_x : last_q;
    end

    // State registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hold0_q  <= '0;
            hold1_q  <= '0;
            last_q   <= '0;
            owner_q  <= OWN_NONE;
            consec_q <= '0;
        end else begin
            hold0_q  <= hold0_d;
            hold1_q  <= hold1_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            consec_q <= consec_d;
        end
    end

    // Slave-side address/data phase and master-side response routing
    always_comb begin
        S_HTRANS  = win_valid ? 2'b10 : 2'b00;
        S_HSEL    = win_valid;
        S_HSIZE   = win_valid ? win_x.size  : last_q.size;
        S_HWRITE  = win_valid ? win_x.write : last_q.write;
        S_HADDR   = win_valid ? win_x.addr  : last_q.addr;
        S_HREADY  = S_HREADYOUT;
        S_HWDATA  = '0;
        M0_HREADY = !(hold0_q.v || (live0 && !grant0));
        M0_HRESP  = '0;
        M0_HRDATA = '0;
        M1_HREADY = !(hold1_q.v || (live1 && !grant1));
        M1_HRESP  = '0;
        M1_HRDATA = '0;
        case (owner_q)
            OWN_M0: begin
                S_HWDATA  = M0_HWDATA;
                M0_HREADY = S_HREADYOUT;
                M0_HRESP  = {1'b0, S_HRESP[0]};
                M0_HRDATA = S_HRDATA;
            end
            OWN_M1: begin
                S_HWDATA  = M1_HWDATA;
                M1_HREADY = S_HREADYOUT;
                M1_HRESP  = {1'b0, S_HRESP[0]};
                M1_HRDATA = S_HRDATA;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aha_code_bus_arbiter.sv
// Directed, table-driven bench for aha_code_bus_arbiter.
module tb_aha_code_bus_arbiter;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] ER = 2'b01;

    logic        HCLK, HRESET;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic        M0_HWRITE, M1_HWRITE;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
    logic        M0_HREADY, M1_HREADY;
    logic [1:0]  M0_HRESP, M1_HRESP;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT;
    logic [1:0]  S_HTRANS, S_HRESP;
    logic [2:0]  S_HSIZE;
    logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;

    int n_checks = 0;
    int n_fail   = 0;

    aha_code_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .M1_MAX_CONSEC(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
        .M0_HADDR(M0_HADDR), .M0_HWDATA(M0_HWDATA),
        .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
        .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
        .M1_HADDR(M1_HADDR), .M1_HWDATA(M1_HWDATA),
        .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
        .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE), .S_HWRITE(S_HWRITE),
        .S_HADDR(S_HADDR), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  m0_trans;
        logic [31:0] m0_addr;
        logic [1:0]  m1_trans;
        logic        m1_write;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        s_ready;
        logic [1:0]  s_resp;
        logic [31:0] s_rdata;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_write;
        logic [2:0]  e_size;
        logic [31:0] e_wdata;
        logic        e_m0_ready;
        logic        e_m1_ready;
        logic [1:0]  e_m0_resp;
        logic [1:0]  e_m1_resp;
        logic [31:0] e_m0_rdata;
        logic [31:0] e_m1_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        M0_HTRANS = ID; M0_HADDR = '0; M0_HWRITE = 1'b0; M0_HWDATA = '0;
        M1_HTRANS = ID; M1_HADDR = '0; M1_HWRITE = 1'b0; M1_HWDATA = '0;
        S_HREADYOUT = 1'b1; S_HRESP = OK; S_HRDATA = '0;
    endtask

    task automatic chk_reset_outputs(input int idx);
        chk("rst_m0_ready", idx, 32'(M0_HREADY), 32'd1);
        chk("rst_m1_ready", idx, 32'(M1_HREADY), 32'd1);
        chk("rst_m0_resp",  idx, 32'(M0_HRESP),  32'd0);
        chk("rst_m1_resp",  idx, 32'(M1_HRESP),  32'd0);
        chk("rst_m0_rdata", idx, M0_HRDATA, 32'd0);
        chk("rst_m1_rdata", idx, M1_HRDATA, 32'd0);
        chk("rst_s_trans",  idx, 32'(S_HTRANS),  32'd0);
        chk("rst_s_sel",    idx, 32'(S_HSEL),    32'd0);
        chk("rst_s_addr",   idx, S_HADDR, 32'd0);
        chk("rst_s_size",   idx, 32'(S_HSIZE),   32'd0);
        chk("rst_s_write",  idx, 32'(S_HWRITE),  32'd0);
        chk("rst_s_wdata",  idx, S_HWDATA, 32'd0);
    endtask

    logic [31:0] st_m1_addr [7];
    logic [31:0] st_exp_addr[7];
    logic        st_exp_m0r [7];
    logic        st_exp_m1r [7];

    initial begin
        HRESET = 1'b1;
        M0_HSIZE = 3'd2; M1_HSIZE = 3'd2;
        drive_idle();
        S_HRDATA = 32'hFEED_F00D;

        //             m0tr m0addr        m1tr w     m1addr        m1wdata       rdy   resp rdata          etr eaddr         ew    esz   ewdata        m0r   m1r   m0rs m1rs m0rdata        m1rdata
        vecs.push_back('{ID, 32'h0,       ID, 1'b0, 32'h0,  32'h0,         1'b1, OK, 32'hDEAD_BEEF, ID, 32'h0,   1'b0, 3'd0, 32'h0,         1'b1, 1'b1, OK, OK, 32'h0,         32'h0});
        vecs.push_back('{NS, 32'h100,     ID, 1'b0, 32'h0,  32'h0,         1'b1, OK, 32'hDEAD_BEEF, NS, 32'h100, 1'b0, 3'd2, 32'h0,         1'b1, 1'b1, OK, OK, 32'h0,         32'h0});
        vecs.push_back('{ID, 32'h0,       ID, 1'b0, 32'h0,  32'h0,         1'b1, OK, 32'hDEAD_BEEF, ID, 32'h100, 1'b0, 3'd2, 32'h0,         1'b1, 1'b1, OK, OK, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{NS, 32'h10,      NS, 1'b1, 32'h20, 32'h0,         1'b1, OK, 32'h0,         NS, 32'h20,  1'b1, 3'd2, 32'h0,         1'b0, 1'b1, OK, OK, 32'h0,         32'h0});
        vecs.push_back('{NS, 32'h10,      ID, 1'b0, 32'h0,  32'h1234_5678, 1'b1, OK, 32'h0,         NS, 32'h10,  1'b0, 3'd2, 32'h1234_5678, 1'b0, 1'b1, OK, OK, 32'h0,         32'h0});
        vecs.push_back('{ID, 32'h0,       ID, 1'b0, 32'h0,  32'h0,         1'b1, OK, 32'hCAFE_0010, ID, 32'h10,  1'b0, 3'd2, 32'h0,         1'b1, 1'b1, OK, OK, 32'hCAFE_0010, 32'h0});
        vecs.push_back('{ID, 32'h0,       NS, 1'b1, 32'h40, 32'h0,         1'b1, OK, 32'h0,         NS, 32'h40,  1'b1, 3'd2, 32'h0,         1'b1, 1'b1, OK, OK, 32'h0,         32'h0});
        for (int w = 0; w < 3; w++)
            vecs.push_back('{NS, 32'h50,  ID, 1'b0, 32'h0,  32'hA5A5_A5A5, 1'b0, OK, 32'h0,         ID, 32'h40,  1'b1, 3'd2, 32'hA5A5_A5A5, 1'b0, 1'b0, OK, OK, 32'h0,         32'h0});
        vecs.push_back('{NS, 32'h50,      ID, 1'b0, 32'h0,  32'hA5A5_A5A5, 1'b1, OK, 32'h0,         NS, 32'h50,  1'b0, 3'd2, 32'hA5A5_A5A5, 1'b0, 1'b1, OK, OK, 32'h0,         32'h0});
        vecs.push_back('{ID, 32'h0,       ID, 1'b0, 32'h0,  32'h0,         1'b1, OK, 32'h5050_5050, ID, 32'h50,  1'b0, 3'd2, 32'h0,         1'b1, 1'b1, OK, OK, 32'h5050_5050, 32'h0});
        vecs.push_back('{NS, 32'h60,      ID, 1'b0, 32'h0,  32'h0,         1'b1, OK, 32'h0,         NS, 32'h60,  1'b0, 3'd2, 32'h0,         1'b1, 1'b1, OK, OK, 32'h0,         32'h0});
        vecs.push_back('{ID, 32'h0,       NS, 1'b1, 32'h70, 32'h0,         1'b0, ER, 32'h0,         ID, 32'h60,  1'b0, 3'd2, 32'h0,         1'b0, 1'b0, ER, OK, 32'h0,         32'h0});
        vecs.push_back('{ID, 32'h0,       NS, 1'b1, 32'h70, 32'h0,         1'b1, ER, 32'h0,         NS, 32'h70,  1'b1, 3'd2, 32'h0,         1'b1, 1'b0, ER, OK, 32'h0,         32'h0});
        vecs.push_back('{ID, 32'h0,       ID, 1'b0, 32'h0,  32'h7777_7777, 1'b1, OK, 32'h1111_2222, ID, 32'h70,  1'b1, 3'd2, 32'h7777_7777, 1'b1, 1'b1, OK, OK, 32'h0,         32'h1111_2222});

        // Reset state, with the slave presenting non-zero read data
        @(negedge HCLK); #2;
        chk_reset_outputs(0);
        @(negedge HCLK); HRESET = 1'b0;

        // Table: M0 alone, collision, slave wait states, error passthrough
        foreach (vecs[i]) begin
            @(negedge HCLK);
            M0_HTRANS = vecs[i].m0_trans; M0_HADDR = vecs[i].m0_addr; M0_HWRITE = 1'b0; M0_HWDATA = '0;
            M1_HTRANS = vecs[i].m1_trans; M1_HADDR = vecs[i].m1_addr; M1_HWRITE = vecs[i].m1_write;
            M1_HWDATA = vecs[i].m1_wdata;
            S_HREADYOUT = vecs[i].s_ready; S_HRESP = vecs[i].s_resp; S_HRDATA = vecs[i].s_rdata;
            #2;
            chk("s_trans",  i, 32'(S_HTRANS), 32'(vecs[i].e_trans));
            chk("s_sel",    i, 32'(S_HSEL),   32'(vecs[i].e_trans[1]));
            chk("s_addr",   i, S_HADDR,       vecs[i].e_addr);
            chk("s_write",  i, 32'(S_HWRITE), 32'(vecs[i].e_write));
            chk("s_size",   i, 32'(S_HSIZE),  32'(vecs[i].e_size));
            chk("s_wdata",  i, S_HWDATA,      vecs[i].e_wdata);
            chk("s_ready",  i, 32'(S_HREADY), 32'(vecs[i].s_ready));
            chk("m0_ready", i, 32'(M0_HREADY), 32'(vecs[i].e_m0_ready));
            chk("m1_ready", i, 32'(M1_HREADY), 32'(vecs[i].e_m1_ready));
            chk("m0_resp",  i, 32'(M0_HRESP),  32'(vecs[i].e_m0_resp));
            chk("m1_resp",  i, 32'(M1_HRESP),  32'(vecs[i].e_m1_resp));
            chk("m0_rdata", i, M0_HRDATA,      vecs[i].e_m0_rdata);
            chk("m1_rdata", i, M1_HRDATA,      vecs[i].e_m1_rdata);
        end

        // Starvation cap: four M1 grants, then M0, then the replayed M1 transfer
        st_m1_addr  = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h214};
        st_exp_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h300, 32'h210, 32'h214};
        st_exp_m0r  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        st_exp_m1r  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge HCLK); drive_idle();
        for (int c = 0; c < 7; c++) begin
            @(negedge HCLK);
            M0_HTRANS = (c < 5) ? NS : ID; M0_HADDR = 32'h300;
            M1_HTRANS = NS; M1_HWRITE = 1'b1; M1_HADDR = st_m1_addr[c];
            #2;
            chk("starve_trans",    c, 32'(S_HTRANS), 32'(NS));
            chk("starve_addr",     c, S_HADDR, st_exp_addr[c]);
            chk("starve_write",    c, 32'(S_HWRITE), (c == 4) ? 32'd0 : 32'd1);
            chk("starve_m0_ready", c, 32'(M0_HREADY), 32'(st_exp_m0r[c]));
            chk("starve_m1_ready", c, 32'(M1_HREADY), 32'(st_exp_m1r[c]));
        end
        @(negedge HCLK); drive_idle();
        @(negedge HCLK);

        // Async reset while M0 is held: outputs return to reset values at once
        @(negedge HCLK);
        M0_HTRANS = NS; M0_HADDR = 32'h400;
        M1_HTRANS = NS; M1_HWRITE = 1'b1; M1_HADDR = 32'h410;
        S_HRDATA = 32'h9999_9999;
        #2;
        chk("pre_rst_addr",     0, S_HADDR, 32'h410);
        chk("pre_rst_m0_ready", 0, 32'(M0_HREADY), 32'd0);
        @(negedge HCLK);
        M1_HTRANS = ID; M1_HWDATA = 32'h5555_AAAA;
        #1 HRESET = 1'b1;
        #1;
        chk_reset_outputs(1);
        @(negedge HCLK); drive_idle();
        @(negedge HCLK); HRESET = 1'b0;
        #2;
        chk("post_rst_trans",    0, 32'(S_HTRANS), 32'd0);
        chk("post_rst_m0_ready", 0, 32'(M0_HREADY), 32'd1);
        @(negedge HCLK);
        M1_HTRANS = NS; M1_HWRITE = 1'b1; M1_HADDR = 32'h480;
        #2;
        chk("post_rst_m1_trans", 0, 32'(S_HTRANS), 32'(NS));
        chk("post_rst_m1_addr",  0, S_HADDR, 32'h480);
        chk("post_rst_m1_ready", 0, 32'(M1_HREADY), 32'd1);
        @(negedge HCLK); drive_idle();
        @(negedge HCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
